// File: rtl/hyperram_frame_requester.sv
// Turns frame commands into HyperRAM queue entries: streams write payload into the controller FIFO,
// waits for the synchronized done pulse, then drains the read buffer with a 2-cycle aligned valid pipe.
module hyperram_frame_requester #(
  parameter int MAX_LEN  = 1280,
  parameter int TIMEOUT  = 65535,
  parameter int RDBUF_AW = 12
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic                cmdValid,
  output logic                cmdReady,
  input  logic                cmdRw,
  input  logic [22:0]         cmdAdr,
  input  logic [10:0]         cmdLen,
  input  logic [7:0]          wrData,
  input  logic                wrValid,
  output logic                wrReady,
  output logic [7:0]          rdData,
  output logic                rdValid,
  output logic                rdLast,
  output logic                errLen,
  output logic                errTimeout,
  output logic                busy,
  output logic [22:0]         adrQueury,
  output logic [10:0]         transactionLenQueury,
  output logic                rwFlagQueury,
  output logic                clockQueury,
  output logic [7:0]          dataInputFifoWrite,
  output logic                WreqFifoWrite,
  input  logic                transferingStatusInfo,
  input  logic [RDBUF_AW-1:0] adrReadInfo,
  output logic [RDBUF_AW-1:0] adrReadRamRead,
  input  logic [7:0]          dataOutRamRead
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_ISSUE, S_WAIT, S_RDRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rw;
  logic [22:0]           r_adr;
  logic [10:0]           r_len;
  logic [10:0]           r_cnt;
  logic [10:0]           r_idx;
  logic [TW-1:0]         r_tmo;
  logic [RDBUF_AW-1:0]   r_base;
  logic                  r_sync1, r_sync2, r_sync3;
  logic                  r_v1, r_v2, r_l1, r_l2;
  logic                  r_err_len, r_err_tmo;

  logic w_accept, w_bad_len, w_done_edge, w_done_ok, w_tmo_hit, w_adr_vld, w_wr_take, w_q_hold;

  assign w_accept    = cmdValid && (r_state == S_IDLE);
  assign w_bad_len   = (cmdLen == 11'd0) || (cmdLen > 11'(MAX_LEN));
  assign w_done_edge = r_sync2 && !r_sync3;
  // The controller needs two cycles to sample the queue pulse before a done edge can belong to it.
  assign w_done_ok   = (r_state == S_WAIT) && w_done_edge && (r_tmo >= TW'(2));
  assign w_tmo_hit   = (r_state == S_WAIT) && !w_done_ok && (r_tmo == TW'(TIMEOUT - 1));
  assign w_adr_vld   = (r_state == S_RDRAIN) && (r_idx != r_len);
  assign w_wr_take   = (r_state == S_WLOAD) && wrValid;
  assign w_q_hold    = (r_state == S_ISSUE) || (r_state == S_WAIT);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rw      <= 1'b0;
      r_adr     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_base    <= '0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_l1      <= 1'b0;
      r_l2      <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sync1   <= transferingStatusInfo;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_err_len <= w_accept && w_bad_len;
      r_v1      <= w_adr_vld;
      r_v2      <= r_v1;
      r_l1      <= w_adr_vld && (r_idx == r_len - 11'd1);
      r_l2      <= r_l1;
      if (w_accept) begin
        r_rw      <= cmdRw;
        r_adr     <= cmdAdr;
        r_len     <= cmdLen;
        r_cnt     <= '0;
        r_err_tmo <= 1'b0;
      end
      if (w_wr_take) r_cnt <= r_cnt + 11'd1;
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
        r_idx <= '0;
      end
      if (r_state == S_WAIT) r_tmo <= r_tmo + TW'(1);
      if (w_done_ok) r_base <= adrReadInfo;
      if (w_tmo_hit) r_err_tmo <= 1'b1;
      if (w_adr_vld) r_idx <= r_idx + 11'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_bad_len) w_next = cmdRw ? S_ISSUE : S_WLOAD;
      S_WLOAD:  if (w_wr_take && (r_cnt + 11'd1 == r_len)) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_done_ok)      w_next = r_rw ? S_RDRAIN : S_IDLE;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      // Leave once the last address has entered the second pipe stage; its byte is presented this cycle.
      S_RDRAIN: if ((r_idx == r_len) && !r_v1) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign cmdReady             = (r_state == S_IDLE);
  assign busy                 = (r_state != S_IDLE);
  assign wrReady              = (r_state == S_WLOAD);
  assign WreqFifoWrite        = w_wr_take;
  assign dataInputFifoWrite   = w_wr_take ? wrData : 8'd0;
  assign clockQueury          = (r_state == S_ISSUE);
  assign adrQueury            = w_q_hold ? r_adr : 23'd0;
  assign transactionLenQueury = w_q_hold ? r_len : 11'd0;
  assign rwFlagQueury         = w_q_hold ? r_rw : 1'b0;
  assign adrReadRamRead       = w_adr_vld ? r_base + RDBUF_AW'(r_idx) : '0;
  assign rdValid              = r_v2;
  assign rdLast               = r_l2;
  assign rdData               = r_v2 ? dataOutRamRead : 8'd0;
  assign errLen               = r_err_len;
  assign errTimeout           = r_err_tmo;
endmodule

// File: tb/tb_hyperram_frame_requester.sv
// Scoreboard bench: directed commands push expected FIFO bytes, queue entries and read bytes;
// a negedge monitor pops and compares whenever the DUT strobes one of them.
module tb_hyperram_frame_requester;
  logic        clk_50 = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady, cmdRw;
  logic [22:0] cmdAdr;
  logic [10:0] cmdLen;
  logic [7:0]  wrData;
  logic        wrValid, wrReady;
  logic [7:0]  rdData;
  logic        rdValid, rdLast, errLen, errTimeout, busy;
  logic [22:0] adrQueury;
  logic [10:0] transactionLenQueury;
  logic        rwFlagQueury, clockQueury;
  logic [7:0]  dataInputFifoWrite;
  logic        WreqFifoWrite;
  logic        transferingStatusInfo;
  logic [11:0] adrReadInfo, adrReadRamRead;
  logic [7:0]  dataOutRamRead;

  hyperram_frame_requester #(.MAX_LEN(1280), .TIMEOUT(100), .RDBUF_AW(12)) dut (
    .clk_50(clk_50), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRw(cmdRw),
    .cmdAdr(cmdAdr), .cmdLen(cmdLen), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .rdLast(rdLast), .errLen(errLen), .errTimeout(errTimeout),
    .busy(busy), .adrQueury(adrQueury), .transactionLenQueury(transactionLenQueury),
    .rwFlagQueury(rwFlagQueury), .clockQueury(clockQueury), .dataInputFifoWrite(dataInputFifoWrite),
    .WreqFifoWrite(WreqFifoWrite), .transferingStatusInfo(transferingStatusInfo),
    .adrReadInfo(adrReadInfo), .adrReadRamRead(adrReadRamRead), .dataOutRamRead(dataOutRamRead)
  );

  always #10 clk_50 = ~clk_50;

  // Read buffer with two register stages between address and data.
  logic [7:0] rdbuf [0:4095];
  logic [7:0] d1, d2;
  always @(posedge clk_50) begin
    d1 <= rdbuf[adrReadRamRead];
    d2 <= d1;
  end
  assign dataOutRamRead = d2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_q_cyc = -100;
  int n_errlen = 0;
  logic [7:0]  exp_wr[$];
  logic [34:0] exp_q[$];
  logic [8:0]  exp_rd[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_50) cyc <= cyc + 1;

  always @(negedge clk_50) begin
    if (!reset) begin
      if (WreqFifoWrite) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_byte", dataInputFifoWrite, exp_wr.pop_front());
      end
      if (clockQueury) begin
        if (exp_q.size() == 0) chk("queue_unexpected", 1, 0);
        else chk("queue_entry", {rwFlagQueury, adrQueury, transactionLenQueury}, exp_q.pop_front());
        if (last_q_cyc >= 0) chk("queue_gap_ge4", (cyc - last_q_cyc) >= 4, 1);
        last_q_cyc = cyc;
      end
      if (rdValid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_byte_last", {rdLast, rdData}, exp_rd.pop_front());
      end
      if (errLen) n_errlen++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [22:0] adr, input logic [10:0] len);
    for (int i = 0; i < 200 && !cmdReady; i++) tick();
    chk("cmd_ready_wait", cmdReady, 1);
    cmdValid = 1'b1; cmdRw = rw; cmdAdr = adr; cmdLen = len;
    tick();
    cmdValid = 1'b0;
  endtask

  task automatic done_pulse();
    transferingStatusInfo = 1'b1;
    tick(3);
    transferingStatusInfo = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk(name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wb [4];
    reset = 1'b1; cmdValid = 1'b0; cmdRw = 1'b0; cmdAdr = '0; cmdLen = '0;
    wrData = '0; wrValid = 1'b0; transferingStatusInfo = 1'b0; adrReadInfo = '0;
    for (int i = 0; i < 4096; i++) rdbuf[i] = 8'(i ^ 8'h5C);
    tick(3);
    reset = 1'b0;
    @(negedge clk_50);
    chk("rst_cmdReady", cmdReady, 1);
    chk("rst_outputs", {busy, wrReady, rdValid, rdLast, errLen, errTimeout, clockQueury, WreqFifoWrite}, 0);
    chk("rst_queue_fields", {adrQueury, transactionLenQueury, rwFlagQueury}, 0);

    // 1: write four bytes with a one-cycle payload gap
    wb[0] = 8'hA0; wb[1] = 8'hA1; wb[2] = 8'hA2; wb[3] = 8'hA3;
    for (int i = 0; i < 4; i++) exp_wr.push_back(wb[i]);
    exp_q.push_back({1'b0, 23'h000100, 11'd4});
    tick();
    send_cmd(1'b0, 23'h000100, 11'd4);
    chk("t1_wrReady", wrReady, 1);
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1; wrData = wb[i];
      tick();
      if (i == 1) begin
        wrValid = 1'b0;
        tick();
      end
    end
    wrValid = 1'b0;
    chk("t1_wrReady_drop", wrReady, 0);
    tick(4);
    done_pulse();
    wait_idle("t1_idle");
    chk("t1_wr_drained", exp_wr.size(), 0);

    // 2: read of three bytes from buffer base 0x010
    rdbuf[12'h010] = 8'h11; rdbuf[12'h011] = 8'h22; rdbuf[12'h012] = 8'h33;
    adrReadInfo = 12'h010;
    exp_q.push_back({1'b1, 23'h7FFFF0, 11'd3});
    exp_rd.push_back({1'b0, 8'h11}); exp_rd.push_back({1'b0, 8'h22}); exp_rd.push_back({1'b1, 8'h33});
    send_cmd(1'b1, 23'h7FFFF0, 11'd3);
    tick(5);
    done_pulse();
    wait_idle("t2_idle");
    chk("t2_rd_drained", exp_rd.size(), 0);

    // 3: read across the buffer wrap point
    rdbuf[12'hFFE] = 8'h5A; rdbuf[12'hFFF] = 8'h6B; rdbuf[12'h000] = 8'h7C; rdbuf[12'h001] = 8'h8D;
    adrReadInfo = 12'hFFE;
    exp_q.push_back({1'b1, 23'h000200, 11'd4});
    exp_rd.push_back({1'b0, 8'h5A}); exp_rd.push_back({1'b0, 8'h6B});
    exp_rd.push_back({1'b0, 8'h7C}); exp_rd.push_back({1'b1, 8'h8D});
    send_cmd(1'b1, 23'h000200, 11'd4);
    tick(6);
    done_pulse();
    wait_idle("t3_idle");
    chk("t3_rd_drained", exp_rd.size(), 0);

    // 4: illegal lengths, plus a stray payload byte and stray done while idle
    send_cmd(1'b0, 23'h000010, 11'd0);
    @(negedge clk_50);
    chk("t4_errLen_len0", errLen, 1);
    chk("t4_idle_len0", {cmdReady, busy}, 2'b10);
    wrValid = 1'b1; wrData = 8'hFF;
    tick();
    wrValid = 1'b0;
    @(negedge clk_50);
    chk("t4_errLen_clear", errLen, 0);
    send_cmd(1'b1, 23'h000020, 11'd1281);
    @(negedge clk_50);
    chk("t4_errLen_len1281", errLen, 1);
    chk("t4_idle_len1281", {cmdReady, busy}, 2'b10);
    done_pulse();
    tick(4);
    chk("t4_errLen_count", n_errlen, 2);

    // 5: read with no completion times out; next command clears the flag
    exp_q.push_back({1'b1, 23'h000300, 11'd2});
    send_cmd(1'b1, 23'h000300, 11'd2);
    tick(99);
    @(negedge clk_50);
    chk("t5_before_timeout", {errTimeout, busy}, 2'b01);
    tick(2);
    @(negedge clk_50);
    chk("t5_timeout", {errTimeout, busy, cmdReady}, 3'b101);
    exp_wr.push_back(8'hEE);
    exp_q.push_back({1'b0, 23'h000500, 11'd1});
    tick();
    send_cmd(1'b0, 23'h000500, 11'd1);
    chk("t5_err_cleared", errTimeout, 0);
    wrValid = 1'b1; wrData = 8'hEE;
    tick();
    wrValid = 1'b0;
    tick(3);
    done_pulse();
    wait_idle("t5_idle");

    // 6: reset in the middle of a 16-byte payload
    for (int i = 0; i < 7; i++) exp_wr.push_back(8'(8'h40 + i));
    send_cmd(1'b0, 23'h000400, 11'd16);
    for (int i = 0; i < 7; i++) begin
      wrValid = 1'b1; wrData = 8'(8'h40 + i);
      tick();
    end
    wrValid = 1'b0;
    reset = 1'b1;
    tick();
    wrValid = 1'b1;
    @(negedge clk_50);
    chk("t6_reset_strobes", {wrReady, WreqFifoWrite, cmdReady}, 3'b001);
    tick();
    wrValid = 1'b0;
    reset = 1'b0;
    tick(3);

    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_q_queue", exp_q.size(), 0);
    chk("end_rd_queue", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
